// File: rtl/sd_block_buffer_if.sv
// sd_block_buffer_if
//   Groups the two byte-wide buses of the SD block buffer:
//   - capture stream : din, din_valid (SD controller -> buffer)
//   - readout port   : rd_req, rd_rewind (front-end -> buffer),
//                      rd_data, rd_valid (buffer -> front-end)
//   master : the side that supplies bytes and issues read requests
//   slave  : the block buffer itself
interface sd_block_buffer_if;
    logic [7:0] din;
    logic       din_valid;
    logic       rd_req;
    logic       rd_rewind;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output din, din_valid, rd_req, rd_rewind,
        input  rd_data, rd_valid
    );

    modport slave (
        input  din, din_valid, rd_req, rd_rewind,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/sd_block_buffer.sv
// sd_block_buffer
//   Captures one SD data block plus its 2-byte CRC16 trailer into on-chip
//   RAM, checks the CRC16-CCITT (0x1021, init 0, MSB-first) over the data
//   bytes, and lets the register front-end read the block back byte by
//   byte through an auto-incrementing, wrapping read pointer.
// Ports:
//   clk96m    : system clock (single domain)
//   rst       : synchronous, active-high reset
//   arm       : pulse, restart capture of a new block (wins over din_valid)
//   io        : din/din_valid capture stream and rd_req/rd_rewind ->
//               rd_data/rd_valid readout (1-cycle latency)
//   busy      : capture in progress (FILL, CRC_HI, CRC_LO)
//   done      : block and CRC trailer captured
//   crc_ok    : received CRC equals computed CRC, meaningful when done=1
//   byte_cnt  : data bytes stored so far, 0..BLOCK_LEN
//   overflow  : sticky, a byte arrived while not capturing
module sd_block_buffer #(
    parameter int BLOCK_LEN = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk96m,
    input  logic              rst,
    input  logic              arm,
    sd_block_buffer_if.slave  io,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic [ADDR_W:0]   byte_cnt,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CRC_HI,
        CRC_LO,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(BLOCK_LEN - 1);

    state_t            state;
    logic [15:0]       crc;
    logic [7:0]        crc_rx_hi;
    logic [7:0]        mem [BLOCK_LEN];
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        ram_q_p1;
    logic              rd_valid_p1;
    logic              rd_sel_p1;
    logic              wr_en;
    logic              rd_hit;

    // One data byte folded into the CRC per cycle, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // arm takes priority, so a byte arriving with arm never reaches the RAM.
    assign wr_en  = (state == FILL) && io.din_valid && !arm;
    assign rd_hit = io.rd_req && (state == DONE);

    always_ff @(posedge clk96m) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            crc      <= 16'h0000;
        end else if (arm) begin
            state    <= FILL;
            busy     <= 1'b1;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            crc      <= 16'h0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (io.din_valid) overflow <= 1'b1;
                end
                FILL: begin
                    if (io.din_valid) begin
                        byte_cnt <= byte_cnt + (ADDR_W+1)'(1);
                        crc      <= crc16_byte(crc, io.din);
                        if (byte_cnt == LAST_IDX) state <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (io.din_valid) state <= CRC_LO;
                end
                CRC_LO: begin
                    if (io.din_valid) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        crc_ok <= ({crc_rx_hi, io.din} == crc);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Received CRC high byte is plain data, held until the low byte arrives.
    always_ff @(posedge clk96m) begin
        if (state == CRC_HI && io.din_valid) crc_rx_hi <= io.din;
    end

    // Block RAM: write port driven by capture, registered read port.
    always_ff @(posedge clk96m) begin
        if (wr_en) mem[byte_cnt[ADDR_W-1:0]] <= io.din;
        ram_q_p1 <= mem[rd_ptr];
    end

    // ---- read request stage -> p1 (response) ----
    // rd_sel_p1 remembers whether the request was served from the RAM;
    // requests outside DONE still pulse rd_valid but return zero.
    always_ff @(posedge clk96m) begin
        if (rst) begin
            rd_valid_p1 <= 1'b0;
            rd_sel_p1   <= 1'b0;
            rd_ptr      <= '0;
        end else begin
            rd_valid_p1 <= io.rd_req;
            rd_sel_p1   <= rd_hit;
            if (arm || io.rd_rewind) rd_ptr <= '0;
            else if (rd_hit)         rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    assign io.rd_valid = rd_valid_p1;
    assign io.rd_data  = rd_sel_p1 ? ram_q_p1 : 8'h00;

endmodule

// File: tb/tb_sd_block_buffer.sv
module tb_sd_block_buffer;
    localparam int BLOCK_LEN = 512;
    localparam int ADDR_W    = 9;

    logic            clk96m = 1'b0;
    logic            rst    = 1'b1;
    logic            arm    = 1'b0;
    logic            busy, done, crc_ok, overflow;
    logic [ADDR_W:0] byte_cnt;

    sd_block_buffer_if io ();

    sd_block_buffer #(.BLOCK_LEN(BLOCK_LEN), .ADDR_W(ADDR_W)) dut (
        .clk96m   (clk96m),
        .rst      (rst),
        .arm      (arm),
        .io       (io),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .byte_cnt (byte_cnt),
        .overflow (overflow)
    );

    always #5 clk96m = ~clk96m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model of buffer contents and read pointer.
    logic [7:0] mdl_mem [BLOCK_LEN];
    bit         mdl_done = 0;
    int         mdl_ptr  = 0;
    logic [7:0] exp_q [$];

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    // Scoreboard: rd_valid must follow each accepted rd_req by exactly one cycle.
    logic req_at_edge = 1'b0;
    always @(posedge clk96m) req_at_edge = io.rd_req && !rst;

    always @(negedge clk96m) begin
        if (req_at_edge || io.rd_valid) begin
            chk("rd_valid_timing", io.rd_valid, req_at_edge);
            if (io.rd_valid) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", io.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk96m);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        mdl_done = 0;
        mdl_ptr  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        io.din = b;
        io.din_valid = 1'b1;
        tick();
        io.din_valid = 1'b0;
    endtask

    // kind 0: all 0xFF, 1: all 0x00, 2: i&0xFF, 3: (i*7+3)&0xFF
    task automatic send_block(input int kind, input bit good_crc, input logic [15:0] bad);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            case (kind)
                0:       b = 8'hFF;
                1:       b = 8'h00;
                2:       b = 8'(i);
                default: b = 8'(i * 7 + 3);
            endcase
            mdl_mem[i] = b;
            c = crc_upd(c, b);
            send_byte(b);
        end
        if (!good_crc) c = bad;
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        mdl_done = 1;
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) begin
            io.rd_req = 1'b1;
            if (mdl_done) begin
                exp_q.push_back(mdl_mem[mdl_ptr]);
                mdl_ptr = (mdl_ptr + 1) % BLOCK_LEN;
            end else begin
                exp_q.push_back(8'h00);
            end
            tick();
        end
        io.rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic rewind(input bit with_req);
        io.rd_rewind = 1'b1;
        io.rd_req    = with_req;
        if (with_req) exp_q.push_back(mdl_done ? mdl_mem[mdl_ptr] : 8'h00);
        mdl_ptr = 0;
        tick();
        io.rd_rewind = 1'b0;
        io.rd_req    = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.din = 8'h00;
        io.din_valid = 1'b0;
        io.rd_req = 1'b0;
        io.rd_rewind = 1'b0;
        tick();
        tick();
        chk("rst_rd_data", io.rd_data, 8'h00);
        chk("rst_rd_valid", io.rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // All 0xFF with known CRC 0x7FA1
        do_arm();
        chk("t1_busy_fill", busy, 1);
        send_block(0, 0, 16'h7FA1);
        chk("t1_done", done, 1);
        chk("t1_crc_ok", crc_ok, 1);
        chk("t1_byte_cnt", byte_cnt, 512);
        chk("t1_busy", busy, 0);
        chk("t1_overflow", overflow, 0);

        // Zeros with bad CRC; full readout plus wrap
        do_arm();
        send_block(1, 0, 16'h1234);
        chk("t2_done", done, 1);
        chk("t2_crc_ok", crc_ok, 0);
        rd(513);

        // Ramp with correct CRC; rewind behaviour
        do_arm();
        send_block(2, 1, 16'h0000);
        chk("t3_crc_ok", crc_ok, 1);
        rd(10);
        rewind(0);
        rd(1);
        rd(4);
        rewind(1);
        rd(2);

        // Abandoned partial block, then a full one
        do_arm();
        for (int i = 0; i < 300; i++) send_byte(8'(i + 8'h55));
        chk("t4_partial_cnt", byte_cnt, 300);
        do_arm();
        send_block(3, 1, 16'h0000);
        chk("t4_byte_cnt", byte_cnt, 512);
        chk("t4_crc_ok", crc_ok, 1);
        rd(512);

        // Byte while DONE: overflow, RAM untouched
        send_byte(8'hAA);
        chk("t5_overflow", overflow, 1);
        chk("t5_done_hold", done, 1);
        rewind(0);
        rd(2);
        do_arm();
        chk("t5_arm_clears_ovf", overflow, 0);
        chk("t5_arm_clears_done", done, 0);
        rd(1);

        // Byte together with arm is dropped silently
        io.din = 8'hEE;
        io.din_valid = 1'b1;
        do_arm();
        io.din_valid = 1'b0;
        chk("t5_arm_drop_cnt", byte_cnt, 0);
        chk("t5_arm_drop_ovf", overflow, 0);

        // Reset in the middle of FILL
        for (int i = 0; i < 199; i++) send_byte(8'(i));
        chk("t6_cnt_before", byte_cnt, 199);
        rst = 1'b1;
        io.din = 8'hC7;
        io.din_valid = 1'b1;
        tick();
        rst = 1'b0;
        io.din_valid = 1'b0;
        mdl_done = 0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_byte_cnt", byte_cnt, 0);
        chk("t6_overflow_clr", overflow, 0);
        send_byte(8'h11);
        chk("t6_overflow_idle", overflow, 1);
        chk("t6_cnt_idle", byte_cnt, 0);
        rd(1);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sd_block_buffer.md
Name: sd_block_buffer

Overview:
- Downstream consumer of the SD controller's read data stream (data_out / data_out_valid).
- Captures one data block plus its 2-byte CRC16 trailer into on-chip RAM and checks the CRC.
- Lets the UART register front-end read the block back byte by byte, with an auto-incrementing read pointer.
- Runs entirely in the clk96m domain.

Parameters:
BLOCK_LEN, 512, data bytes per block (power of two)
ADDR_W, 9, log2(BLOCK_LEN); RAM address width

Ports:
clk96m  in  1  system clock, 96 MHz
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle pulse: clear buffer state and wait for a new block
din  in  8  byte from SD controller
din_valid  in  1  din qualifier, at most one byte per cycle
rd_req  in  1  one-cycle pulse: read next buffered byte
rd_rewind  in  1  one-cycle pulse: reset read pointer to 0
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse, rd_data valid
busy  out  1  capture in progress (FILL/CRC_HI/CRC_LO)
done  out  1  block plus CRC captured
crc_ok  out  1  received CRC equals computed CRC; valid when done=1
byte_cnt  out  ADDR_W+1  data bytes stored so far (0..BLOCK_LEN)
overflow  out  1  sticky: din_valid seen while in IDLE or DONE

Behaviour:
- Reset values: rd_data=8'h00, rd_valid=0, busy=0, done=0, crc_ok=0, byte_cnt=0, overflow=0, read pointer=0, state=IDLE.
- Reset mid-capture aborts the capture and returns to IDLE. RAM contents are don't-care after reset.

States:
- IDLE: waits for arm.
  - arm -> FILL; clears byte_cnt, CRC register (0x0000), done, crc_ok, overflow and read pointer.
- FILL: each din_valid writes din at address byte_cnt, increments byte_cnt and updates the CRC.
  - After the byte that makes byte_cnt==BLOCK_LEN -> CRC_HI.
- CRC_HI: din_valid latches the received CRC [15:8] -> CRC_LO.
- CRC_LO: din_valid latches the received CRC [7:0]; the next cycle is DONE, with done=1 and crc_ok=(received==computed).
- DONE: holds until arm (-> FILL with the same clearing as IDLE).

CRC:
- CRC16-CCITT, polynomial x^16+x^12+x^5+1 (0x1021), initial value 0x0000, MSB-first, no final XOR.
- Covers the data bytes only.
- One byte per cycle using a combinational 8-step update.

Flags and precedence:
- busy=1 exactly in FILL, CRC_HI and CRC_LO.
- arm in any state restarts the capture (arm wins over a simultaneous din_valid). A byte arriving in the same cycle as arm is dropped and does not set overflow.
- din_valid in IDLE or DONE without arm is ignored and sets overflow (sticky until arm or rst).

Readout:
- rd_req at cycle N gives rd_valid=1 and rd_data at cycle N+1 (synchronous RAM read, 1-cycle latency).
- In DONE: rd_data = RAM[rd_ptr]; rd_ptr increments and wraps from BLOCK_LEN-1 to 0.
- In any other state: rd_valid still pulses, rd_data=8'h00, rd_ptr unchanged.
- rd_rewind sets rd_ptr=0 and wins over a simultaneous rd_req (that read returns the byte at the old pointer, then the pointer becomes 0).
- Back-to-back rd_req on consecutive cycles is legal: one byte per cycle.
- Writes and reads never conflict because reads return data only in DONE.

Test Plan:
- arm; 512 bytes of 0xFF, then 0x7F, 0xA1 -> done=1, crc_ok=1, byte_cnt=512, busy=0, overflow=0.
- arm; 512 bytes of 0x00, then 0x12, 0x34 -> done=1, crc_ok=0; 512 rd_req return 0x00; the 513th returns byte 0 again (wrap).
- arm; bytes i&0xFF with correct CRC; read 10 bytes -> 0x00..0x09; rd_rewind; rd_req -> 0x00; rd_valid exactly 1 cycle after each rd_req.
- arm; 300 bytes; arm again; full 512-byte block with good CRC -> byte_cnt=512, crc_ok=1, readback shows only the second block's data.
- In DONE, din_valid with 0xAA -> overflow=1, RAM unchanged; next arm clears overflow. rd_req in IDLE -> rd_valid=1, rd_data=0x00.
- rst asserted in the middle of FILL (byte 200) -> the next cycle has state IDLE, busy=0, done=0, byte_cnt=0; further din_valid sets overflow.
